bin_to_bcd_converter: RTL
=========================

// Module: bin_to_bcd_converter
// PURPOSE
//   Sequential double-dabble converter: turns an unsigned binary value into packed BCD digits.
//   Sits directly upstream of the per-digit seven-segment decoders. Each 4-bit digit of bcd
//   drives one decoder's number input. Also produces a leading-zero blank mask for display muxing.
//   One conversion in flight at a time, start/busy/done handshake; outputs hold between conversions.
// PARAMETERS
//   BIN_WIDTH  16  width of binary input, >= 1
//   DIGITS     5   number of BCD digits produced, >= 1
// PORTS
//   clk       in   1            system clock, rising edge
//   reset_n   in   1            asynchronous active-low reset
//   start     in   1            request conversion of binary; sampled only in IDLE
//   binary    in   BIN_WIDTH    unsigned value, captured on accepted start
//   busy      out  1            high while a conversion is in progress (SHIFT state)
//   done      out  1            one-cycle pulse: bcd/blank/overflow updated this cycle
//   bcd       out  4*DIGITS     packed BCD, digit 0 (units) in [3:0]
//   blank     out  DIGITS       bit i = 1: digit i is a leading zero (digit 0 never blanked)
//   overflow  out  1            last result exceeded 10^DIGITS-1; bcd saturated
// BEHAVIOUR
//   Reset (async assert, sync-released by system): state=IDLE, busy=0, done=0, bcd=0,
//     overflow=0, blank={DIGITS-1{1},1'b0}. Reset mid-conversion aborts it; no done pulse.
//   States: IDLE -> SHIFT -> FINISH -> IDLE.
//   IDLE: start=1 -> latch binary into shift reg, clear scratch digits and ovf flag,
//     bit counter=BIN_WIDTH, go SHIFT. start=0 -> stay.
//   SHIFT (busy=1): per cycle, for every scratch digit >=5 add 3, then shift {scratch,shreg}
//     left one bit, MSB of binary entering digit 0 LSB. Bit leaving top digit MSB = 1 sets
//     sticky ovf. Counter decrements; after BIN_WIDTH shift cycles go FINISH.
//   FINISH (busy=0): register outputs, done=1 this cycle only, go IDLE.
//     ovf=0: bcd=scratch, overflow=0. ovf=1: bcd=all digits 4'd9, overflow=1.
//     blank[i]=1 iff digits i..DIGITS-1 of new bcd all zero, i>0; blank[0]=0.
//   Latency: start accepted at edge N -> done high in cycle after edge N+BIN_WIDTH+1.
//     Outputs change only on done. Throughput one conversion per BIN_WIDTH+2 cycles.
//   start while busy or in FINISH: ignored, not queued. start in the cycle after done is accepted.
//   binary may change freely after acceptance; only latched value converted.
//   Add-3 correction uses 4-bit arithmetic per digit; no digit ever holds 10..15 after shift.
//   BIN_WIDTH=1: single shift cycle, result 0 or 1.
// TESTING
//   reset, BIN_WIDTH=16 DIGITS=5, binary=65535 start 1 cycle -> done after 17 edges,
//     bcd=20'h65535, blank=5'b00000, overflow=0; busy high exactly 16 cycles.
//   binary=0 -> bcd=20'h00000, blank=5'b11110, overflow=0.
//   binary=1234 -> bcd=20'h01234, blank=5'b10000; binary=9 -> bcd=20'h00009, blank=5'b11110.
//   DIGITS=4, binary=12345 -> overflow=1, bcd=16'h9999; next binary=9999 -> overflow=0, bcd=16'h9999.
//   start pulsed while busy with other binary -> ignored, single done with first result;
//     start held high continuously -> back-to-back conversions every 18 cycles.
//   reset_n low at 8th SHIFT cycle -> immediately busy=0, bcd=0, blank=5'b11110, no done;
//     after release new start converts 42 -> bcd=20'h00042.

Source files
------------

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with a saturating overflow flag
// and a leading-zero blank mask for the downstream seven-segment display mux.
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] shreg;
  logic [SW-1:0]        scratch;
  logic [SW-1:0]        adj;
  logic [SW-1:0]        bcd_next;
  logic [DIGITS-1:0]    blank_next;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic                 zero_run;

  // Add-3 correction on every scratch digit before it is doubled by the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Result formatting: saturate on overflow, then mark the run of leading zeros.
  always_comb begin
    bcd_next   = ovf ? {DIGITS{4'd9}} : scratch;
    blank_next = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (bcd_next[4*i +: 4] == 4'd0);
      blank_next[i] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
      overflow <= 1'b0;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= binary;
            scratch <= '0;
            ovf     <= 1'b0;
            cnt     <= CW'(BIN_WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // A one leaving the top digit means the value cannot fit in DIGITS digits.
          scratch <= {adj[SW-2:0], shreg[BIN_WIDTH-1]};
          shreg   <= shreg << 1;
          ovf     <= ovf | adj[SW-1];
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
          bcd      <= bcd_next;
          blank    <= blank_next;
          overflow <= ovf;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
